// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg
// Shared constants and the controller state type for the 8-input
// interrupt arbiter (irq_arbiter_8) and its priority encoder (prio_enc8).
//   N_REQ   : number of interrupt request lines
//   VEC_W   : width of the binary vector index
//   state_t : arbiter states IDLE / REQ / SERVICE
package irq_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_arbiter_8_prio_enc8.sv
// prio_enc8
// Purely combinational priority encoder with a movable top priority.
// Bit 'base' is searched first, then base-1, base-2, ... wrapping mod 8,
// so base=7 gives plain "highest index wins" priority.
// Ports:
//   req   [7:0] in  : candidate request vector
//   base  [2:0] in  : bit index that currently has the highest priority
//   valid       out : at least one bit of req is set
//   index [2:0] out : winning bit index (0 when valid=0)
module prio_enc8
  import irq_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [VEC_W-1:0] base,
  output logic             valid,
  output logic [VEC_W-1:0] index
);

  logic [VEC_W-1:0] pos;

  // Scan from the lowest-priority position up to 'base'; the last hit
  // overwrites earlier ones, so the highest-priority set bit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    pos   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = base - VEC_W'(k);
      if (req[pos]) begin
        valid = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter_8.sv
// irq_arbiter_8
// 8-input interrupt arbiter with edge-detected request latching, per-bit
// masking, fixed (or optionally rotating) priority, an acknowledge
// handshake with timeout, and an end-of-interrupt release.
// Optional feature: define IRQ_ARBITER_ROUND_ROBIN_EN to rotate priority
// after each acknowledge (bit v-1 becomes highest after vector v).
// Parameters:
//   ACK_TIMEOUT : cycles spent in REQ without ack before giving up (2..255)
// Ports:
//   clk        in  : clock, rising edge
//   rst_n      in  : synchronous active-low reset
//   req_n[7:0] in  : active-low requests, falling edge latches pending
//   ei_n       in  : active-low enable input
//   mask_wr    in  : mask write strobe
//   mask_data  in  : new mask (1 = masked)
//   ack        in  : host acknowledge of the presented vector
//   eoi        in  : end of interrupt
//   irq        out : interrupt request to the host
//   vec[2:0]   out : selected vector index
//   gs_n       out : enabled and something eligible
//   eo_n       out : enabled and nothing eligible
//   busy       out : request in service
//   timeout    out : one-cycle pulse on acknowledge timeout
module irq_arbiter_8
  import irq_arbiter_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_n,
  input  logic             ei_n,
  input  logic             mask_wr,
  input  logic [N_REQ-1:0] mask_data,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [VEC_W-1:0] vec,
  output logic             gs_n,
  output logic             eo_n,
  output logic             busy,
  output logic             timeout
);

  localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

  state_t           state;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] fall;
  logic [N_REQ-1:0] clr;
  logic [7:0]       wait_cnt;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] rr_base;
  logic [VEC_W-1:0] sel_idx;
  logic             sel_valid;
  logic             ack_take;

  // A request edge is a 1 in the registered copy while the live input is 0.
  assign fall     = req_q & ~req_n;
  assign eligible = pending & ~mask;

  // Acknowledge only counts in REQ while still enabled; ei_n=1 wins over it.
  assign ack_take = (state == ST_REQ) && !ei_n && ack;
  assign clr      = ack_take ? (N_REQ'(1) << vec_q) : '0;

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
  // After servicing vector v, the bit just below it becomes top priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_base <= 3'd7;
    end else if (ack_take) begin
      rr_base <= vec_q - 3'd1;
    end
  end
`else
  assign rr_base = 3'd7;
`endif

  prio_enc8 u_enc (
    .req   (eligible),
    .base  (rr_base),
    .valid (sel_valid),
    .index (sel_idx)
  );

  // Request capture, mask and the IDLE/REQ/SERVICE handshake.
  // Pending is updated with set-wins priority over the ack clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q    <= '1;
      pending  <= '0;
      mask     <= '0;
      state    <= ST_IDLE;
      wait_cnt <= '0;
      vec_q    <= '0;
      irq      <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      req_q   <= req_n;
      pending <= (pending & ~clr) | fall;
      timeout <= 1'b0;
      if (mask_wr) begin
        mask <= mask_data;
      end
      case (state)
        ST_IDLE: begin
          if (!ei_n && sel_valid) begin
            state    <= ST_REQ;
            vec_q    <= sel_idx;
            irq      <= 1'b1;
            wait_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (ei_n) begin
            state <= ST_IDLE;
            irq   <= 1'b0;
          end else if (ack) begin
            state <= ST_SERVICE;
            irq   <= 1'b0;
            busy  <= 1'b1;
          end else if (wait_cnt == LAST_WAIT) begin
            state   <= ST_IDLE;
            irq     <= 1'b0;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_SERVICE: begin
          if (eoi) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          irq   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // vec is frozen while a request is outstanding, live selection in IDLE.
  assign vec  = (state == ST_IDLE) ? (sel_valid ? sel_idx : '0) : vec_q;
  assign gs_n = ~(~ei_n & sel_valid);
  assign eo_n = ~(~ei_n & ~sel_valid);

endmodule

// File: tb/tb_irq_arbiter_8.sv
// tb_irq_arbiter_8
// Randomized scoreboard bench for irq_arbiter_8 (ACK_TIMEOUT=4). A driver
// issues a few directed scenarios then random traffic, stepping a
// behavioural model each edge and queueing the expected outputs; a monitor
// pops and compares them on the falling edge.
module tb_irq_arbiter_8;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_n;
  logic       ei_n;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] vec;
  logic       gs_n;
  logic       eo_n;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       irq;
    logic [2:0] vec;
    logic       gs_n;
    logic       eo_n;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t sbq[$];

  // Model: "outstanding" = irq raised awaiting ack, "serving" = acked
  bit [7:0] m_pend;
  bit [7:0] m_mask;
  bit [7:0] m_last_req;
  bit       m_outstanding;
  bit       m_serving;
  bit       m_tmo;
  int       m_vec;
  int       m_waited;
  int       m_top;

  always #5 clk = ~clk;

  irq_arbiter_8 #(.ACK_TIMEOUT(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_n     (req_n),
    .ei_n      (ei_n),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .ack       (ack),
    .eoi       (eoi),
    .irq       (irq),
    .vec       (vec),
    .gs_n      (gs_n),
    .eo_n      (eo_n),
    .busy      (busy),
    .timeout   (timeout)
  );

  // Highest-priority set bit, walking downward from m_top; -1 if none.
  function automatic int pick(bit [7:0] e);
    for (int k = 0; k < 8; k++) begin
      int b;
      b = (m_top - k + 8) % 8;
      if (e[b]) return b;
    end
    return -1;
  endfunction

  // Advance the model by one rising edge using the inputs present now.
  task automatic model_step();
    bit [7:0] elig;
    bit [7:0] edges;
    bit [7:0] cleared;
    int       s;
    if (!rst_n) begin
      m_pend = 0; m_mask = 0; m_last_req = 8'hFF;
      m_outstanding = 0; m_serving = 0; m_tmo = 0;
      m_vec = 0; m_waited = 0; m_top = 7;
      return;
    end
    elig    = m_pend & ~m_mask;
    edges   = m_last_req & ~req_n;
    cleared = 0;
    m_tmo   = 0;
    if (m_outstanding) begin
      if (ei_n) begin
        m_outstanding = 0;
      end else if (ack) begin
        cleared[m_vec] = 1;
        m_outstanding  = 0;
        m_serving      = 1;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
        m_top = (m_vec + 7) % 8;
`endif
      end else if (m_waited + 1 >= T) begin
        m_outstanding = 0;
        m_tmo         = 1;
      end else begin
        m_waited++;
      end
    end else if (m_serving) begin
      if (eoi) m_serving = 0;
    end else begin
      s = pick(elig);
      if (!ei_n && s >= 0) begin
        m_outstanding = 1;
        m_vec         = s;
        m_waited      = 0;
      end
    end
    m_pend     = (m_pend & ~cleared) | edges;
    m_last_req = req_n;
    if (mask_wr) m_mask = mask_data;
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    int   s;
    s = pick(m_pend & ~m_mask);
    e.irq     = m_outstanding;
    e.busy    = m_serving;
    e.timeout = m_tmo;
    if (m_outstanding || m_serving) e.vec = 3'(m_vec);
    else                            e.vec = (s < 0) ? 3'd0 : 3'(s);
    e.gs_n = !(ei_n == 1'b0 && s >= 0);
    e.eo_n = !(ei_n == 1'b0 && s < 0);
    return e;
  endfunction

  // Drive one cycle of inputs, queue what the DUT should show, take the edge.
  task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic e,
                               input logic mw, input logic [7:0] md,
                               input logic a, input logic eo);
    rst_n = r; req_n = rq; ei_n = e; mask_wr = mw; mask_data = md;
    ack = a; eoi = eo;
    sbq.push_back(expect_now());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the queued expectation each falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        checkOutput("irq",     8'(irq),     8'(x.irq));
        checkOutput("vec",     8'(vec),     8'(x.vec));
        checkOutput("gs_n",    8'(gs_n),    8'(x.gs_n));
        checkOutput("eo_n",    8'(eo_n),    8'(x.eo_n));
        checkOutput("busy",    8'(busy),    8'(x.busy));
        checkOutput("timeout", 8'(timeout), 8'(x.timeout));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] cur;
    rst_n = 1'b0; req_n = 8'hFF; ei_n = 1'b0; mask_wr = 1'b0;
    mask_data = 8'h00; ack = 1'b0; eoi = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    repeat (2) applyStimulus(0, 8'hFF, 0, 0, 8'h00, 0, 0);
    repeat (2) applyStimulus(1, 8'hFF, 0, 0, 8'h00, 0, 0);

    // Single request on bit 5, then ack and eoi
    repeat (3) applyStimulus(1, 8'hDF, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 8'hDF, 0, 0, 8'h00, 1, 0);
    applyStimulus(1, 8'hFF, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 8'hFF, 0, 0, 8'h00, 0, 1);

    // Bits 6 and 2 together: 6 first, then 2
    repeat (3) applyStimulus(1, 8'hBB, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 8'hBB, 0, 0, 8'h00, 1, 0);
    applyStimulus(1, 8'hFF, 0, 0, 8'h00, 0, 1);
    repeat (2) applyStimulus(1, 8'hFF, 0, 0, 8'h00, 0, 0);

    // Timeout on bit 2 with no ack, repeated retries
    repeat (12) applyStimulus(1, 8'hFF, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 8'hFF, 0, 0, 8'h00, 1, 0);
    applyStimulus(1, 8'hFF, 0, 0, 8'h00, 0, 1);

    // Masked bit 7, then unmask
    applyStimulus(1, 8'hFF, 0, 1, 8'h80, 0, 0);
    repeat (4) applyStimulus(1, 8'h7F, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 8'h7F, 0, 1, 8'h00, 0, 0);
    repeat (3) applyStimulus(1, 8'h7F, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 8'h7F, 0, 0, 8'h00, 1, 0);

    // Reset while in service, with a request held low through reset
    applyStimulus(1, 8'h7F, 0, 0, 8'h00, 0, 0);
    applyStimulus(0, 8'h7F, 0, 0, 8'h00, 0, 0);
    repeat (4) applyStimulus(1, 8'h7F, 0, 0, 8'h00, 0, 0);

    // Random traffic
    cur = 8'h7F;
    for (int i = 0; i < 3000; i++) begin
      cur = cur ^ 8'($urandom & $urandom & $urandom);
      applyStimulus(($urandom_range(0, 199) != 0), cur,
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 19) == 0), 8'($urandom & $urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("sb_drain", 8'(sbq.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_arbiter_8.md
IRQ_ARBITER_8 -- requirements
Module: irq_arbiter_8

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15: the number of cycles in REQ state without ack before the request is abandoned; legal range 2..255.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 req_n  input  8  active-low interrupt requests; bit 7 has the highest priority and bit 0 the lowest.
REQ-005 ei_n  input  1  active-low enable input.
REQ-006 mask_wr  input  1  mask write strobe.
REQ-007 mask_data  input  8  new mask value; a 1 masks the corresponding bit.
REQ-008 ack  input  1  requester acknowledge of the presented vector.
REQ-009 eoi  input  1  end-of-interrupt strobe.
REQ-010 irq  output  1  interrupt request to the host.
REQ-011 vec  output  3  binary index of the selected request.
REQ-012 gs_n  output  1  active-low group select: ei_n=0 and at least one eligible request.
REQ-013 eo_n  output  1  active-low enable output: ei_n=0 and no eligible request.
REQ-014 busy  output  1  high while a request is in service.
REQ-015 timeout  output  1  one-cycle pulse when an acknowledge timeout occurs.

Function
REQ-016 req_n SHALL be registered every cycle; a registered 1->0 transition on bit i SHALL set pending[i] on the next edge.
REQ-017 eligible SHALL equal pending & ~mask; selection SHALL be the highest-index eligible bit (fixed priority).
REQ-018 FSM states SHALL be IDLE, REQ and SERVICE.
REQ-019 IDLE->REQ SHALL occur when ei_n=0 and eligible!=0; vec SHALL be latched and irq=1 from the next cycle.
REQ-020 In REQ, ack=1 SHALL clear pending[vec], enter SERVICE, drop irq and set busy, all on the same edge.
REQ-021 In REQ, an 8-bit wait counter SHALL increment each cycle; at count ACK_TIMEOUT-1 with no ack the FSM SHALL return to IDLE, pulse timeout for 1 cycle and keep pending.
REQ-022 In REQ, ei_n=1 SHALL return the FSM to IDLE and drop irq, with pending unchanged; ack in that same cycle SHALL be ignored.
REQ-023 ack in the same cycle as the timeout count SHALL win: the FSM enters SERVICE and timeout stays 0.
REQ-024 In SERVICE, eoi=1 SHALL return the FSM to IDLE and clear busy; nesting is not supported.
REQ-025 ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-026 vec SHALL be held stable in REQ and SERVICE; in IDLE vec SHALL show the current selection, or 0 when none is eligible.
REQ-027 gs_n and eo_n SHALL be decoded from registered state; both SHALL be 1 when ei_n=1.
REQ-028 mask_wr SHALL update the mask on the next edge; masking the latched vec in REQ or SERVICE SHALL NOT abort it.
REQ-029 A new edge on bit i coincident with the ack clear of bit i SHALL leave pending[i]=1 (set wins).

Reset
REQ-030 While rst_n=0 at an edge, the block SHALL set: pending=0, mask=8'h00, req_n register=8'hFF, state=IDLE, wait counter=0, rotate base=7, irq=0, busy=0, timeout=0.
REQ-031 Reset asserted in any state SHALL abort the operation in progress within one edge; no ack or eoi is required.
REQ-032 A request held low through reset SHALL register as an edge on the first cycle after release.

Configuration
REQ-033 With IRQ_ARBITER_ROUND_ROBIN_EN defined, priority SHALL rotate: after an ack of vector v, bit (v-1) mod 8 becomes the highest priority.
REQ-034 Without IRQ_ARBITER_ROUND_ROBIN_EN, priority SHALL be fixed with bit 7 highest; the rotate base register SHALL NOT exist.

Structure
REQ-035 Package irq_arbiter_pkg SHALL hold N_REQ=8, VEC_W=3 and the FSM state enum.
REQ-036 Sub-module prio_enc8 SHALL be a combinational encoder taking an 8-bit vector and a 3-bit rotate base, and returning valid and index.

Verification
REQ-037 Reset, then req_n[5] 1->0 with ei_n=0 -> irq=1, vec=5 and gs_n=0 two cycles later; ack -> busy=1 and pending[5]=0.
REQ-038 req_n[2] and req_n[6] fall together -> vec=6; after ack and eoi -> vec=2 is presented.
REQ-039 No ack, ACK_TIMEOUT=4 -> timeout pulses 4 cycles after irq rises; irq returns within one cycle; pending is kept.
REQ-040 mask=8'h80 and req_n[7] falls -> irq stays 0 and eo_n=0; clearing the mask -> irq=1 with vec=7.
REQ-041 ROUND_ROBIN build, bits 7 and 3 kept pending -> ack order is 7, 3, 7, 3.
REQ-042 rst_n=0 asserted in SERVICE -> busy=0, irq=0 and pending=0 on the next edge.
